// File: rtl/flappy_pkg.sv
// Shared geometry, physics constants and state encoding for the flappy game engine.
// The VGA renderer imports the same geometry so both sides agree on pixel positions.
package flappy_pkg;

    localparam int DATA_W = 10;
    localparam int VEL_W  = 6;

    typedef logic [DATA_W-1:0]       coord_t;
    typedef logic signed [VEL_W-1:0] vel_t;

    localparam coord_t SCREEN_W     = 10'd640;
    localparam coord_t BIRD_X       = 10'd320;
    localparam coord_t BIRD_SIZE    = 10'd20;
    localparam coord_t PIPE_W       = 10'd40;
    localparam coord_t GAP_H        = 10'd120;
    localparam coord_t GROUND_Y     = 10'd460;
    localparam coord_t BIRD_Y0      = 10'd240;
    localparam coord_t PIPE_SPEED   = 10'd2;
    localparam coord_t PIPE_SPACING = 10'd320;
    localparam coord_t GAP_BASE     = 10'd40;
    localparam coord_t PIPE1_GAP0   = 10'd160;
    localparam coord_t PIPE2_GAP0   = 10'd200;
    localparam coord_t PIPE2_X0     = SCREEN_W + PIPE_SPACING;
    localparam coord_t Y_MAX        = GROUND_Y - BIRD_SIZE;

    localparam vel_t GRAVITY  = 6'sd1;
    localparam vel_t FLAP_VEL = -6'sd6;
    localparam vel_t MAX_FALL = 6'sd8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FLAP,
        ST_HIT,
        ST_HITREST
    } state_t;

endpackage

// File: rtl/flappy_game_engine_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running; supplies pipe gap heights.
module flappy_lfsr16
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= LFSR_SEED;
        end else begin
            out <= {out[0] ^ out[2] ^ out[3] ^ out[5], out[15:1]};
        end
    end

endmodule

// File: rtl/flappy_game_engine.sv
// Flappy game state producer: bird physics, two scrolling pipes, score and collision.
// All outputs are registered and only move on a tick or a button edge.
module flappy_game_engine
    import flappy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flap,
    input  logic              tick,
    output logic [DATA_W-1:0] bird_y,
    output logic [DATA_W-1:0] pipe1_x,
    output logic [DATA_W-1:0] pipe1_gap,
    output logic [DATA_W-1:0] pipe2_x,
    output logic [DATA_W-1:0] pipe2_gap,
    output logic [7:0]        score,
    output logic              hit,
    output logic              q_I,
    output logic              q_flap,
    output logic              q_hit,
    output logic              q_hitrest
);

    function automatic vel_t fall_vel(input vel_t v);
        vel_t s;
        s = v + GRAVITY;
        return (s > MAX_FALL) ? MAX_FALL : s;
    endfunction

    function automatic coord_t clamp_y(input coord_t y, input vel_t v);
        logic signed [DATA_W+1:0] s;
        s = $signed({2'b00, y}) + $signed({{(DATA_W+2-VEL_W){v[VEL_W-1]}}, v});
        if (s[DATA_W+1])                      return '0;
        else if (s[DATA_W:0] > {1'b0, Y_MAX}) return Y_MAX;
        else                                  return s[DATA_W-1:0];
    endfunction

    function automatic logic [7:0] sat_score(input logic [7:0] s, input logic [1:0] inc);
        logic [8:0] t;
        t = {1'b0, s} + {7'b0, inc};
        return t[8] ? 8'hFF : t[7:0];
    endfunction

    function automatic coord_t pipe_step(input coord_t x);
        return (x < PIPE_SPEED) ? SCREEN_W : x - PIPE_SPEED;
    endfunction

    function automatic logic pipe_hit(input coord_t x, input coord_t gap, input coord_t y);
        return (x < BIRD_X + BIRD_SIZE) && (x + PIPE_W > BIRD_X) &&
               ((y < gap) || (y + BIRD_SIZE > gap + GAP_H));
    endfunction

    state_t      state, state_n;
    vel_t        vel, vel_n, fly_vel, fall_v;
    coord_t      y_n, p1x_n, p2x_n, g1_n, g2_n;
    coord_t      fly_y, fall_y, p1x_step, p2x_step, g1_step, g2_step;
    logic [7:0]  score_n;
    logic [15:0] lfsr;
    logic        start_p0, flap_p0, start_edge, flap_edge;
    logic        flap_pend, flap_pend_n;
    logic        pass1, pass2, collide;

    flappy_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (lfsr)
    );

    assign start_edge = start & ~start_p0;
    assign flap_edge  = flap & ~flap_p0;

    // Candidate next values for a flying tick and a falling (post-hit) tick
    assign fall_v   = fall_vel(vel);
    assign fly_vel  = flap_pend ? FLAP_VEL : fall_v;
    assign fly_y    = clamp_y(bird_y, fly_vel);
    assign fall_y   = clamp_y(bird_y, fall_v);
    assign p1x_step = pipe_step(pipe1_x);
    assign p2x_step = pipe_step(pipe2_x);
    assign g1_step  = (pipe1_x < PIPE_SPEED) ? GAP_BASE + {2'b00, lfsr[7:0]}  : pipe1_gap;
    assign g2_step  = (pipe2_x < PIPE_SPEED) ? GAP_BASE + {2'b00, lfsr[15:8]} : pipe2_gap;
    assign pass1    = (pipe1_x + PIPE_W >= BIRD_X) && (p1x_step + PIPE_W < BIRD_X);
    assign pass2    = (pipe2_x + PIPE_W >= BIRD_X) && (p2x_step + PIPE_W < BIRD_X);
    assign collide  = (fly_y + BIRD_SIZE >= GROUND_Y) ||
                      pipe_hit(p1x_step, g1_step, fly_y) ||
                      pipe_hit(p2x_step, g2_step, fly_y);

    always_comb begin
        state_n     = state;
        vel_n       = vel;
        y_n         = bird_y;
        p1x_n       = pipe1_x;
        p2x_n       = pipe2_x;
        g1_n        = pipe1_gap;
        g2_n        = pipe2_gap;
        score_n     = score;
        flap_pend_n = 1'b0;
        case (state)
            ST_INIT: begin
                if (start_edge) state_n = ST_FLAP;
            end
            ST_FLAP: begin
                if (tick) begin
                    vel_n       = fly_vel;
                    y_n         = fly_y;
                    p1x_n       = p1x_step;
                    p2x_n       = p2x_step;
                    g1_n        = g1_step;
                    g2_n        = g2_step;
                    score_n     = sat_score(score, {1'b0, pass1} + {1'b0, pass2});
                    flap_pend_n = flap_edge;
                    if (collide) state_n = ST_HIT;
                end else begin
                    flap_pend_n = flap_pend | flap_edge;
                end
            end
            ST_HIT: begin
                if (tick) begin
                    vel_n = fall_v;
                    y_n   = fall_y;
                    if (fall_y == Y_MAX) state_n = ST_HITREST;
                end
            end
            ST_HITREST: begin
                if (start_edge) begin
                    state_n = ST_INIT;
                    vel_n   = '0;
                    y_n     = BIRD_Y0;
                    p1x_n   = SCREEN_W;
                    p2x_n   = PIPE2_X0;
                    g1_n    = PIPE1_GAP0;
                    g2_n    = PIPE2_GAP0;
                    score_n = '0;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    // Register stage: every output moves exactly one clk after its cause
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            start_p0  <= 1'b1;
            flap_p0   <= 1'b1;
            flap_pend <= 1'b0;
            vel       <= '0;
            bird_y    <= BIRD_Y0;
            pipe1_x   <= SCREEN_W;
            pipe2_x   <= PIPE2_X0;
            pipe1_gap <= PIPE1_GAP0;
            pipe2_gap <= PIPE2_GAP0;
            score     <= '0;
        end else begin
            state     <= state_n;
            start_p0  <= start;
            flap_p0   <= flap;
            flap_pend <= flap_pend_n;
            vel       <= vel_n;
            bird_y    <= y_n;
            pipe1_x   <= p1x_n;
            pipe2_x   <= p2x_n;
            pipe1_gap <= g1_n;
            pipe2_gap <= g2_n;
            score     <= score_n;
        end
    end

    assign hit       = (state == ST_HIT) || (state == ST_HITREST);
    assign q_I       = (state == ST_INIT);
    assign q_flap    = (state == ST_FLAP);
    assign q_hit     = (state == ST_HIT);
    assign q_hitrest = (state == ST_HITREST);

endmodule

// File: tb/tb_flappy_game_engine.sv
// Directed bench for flappy_game_engine: a behavioural game model feeds a scoreboard queue.
module tb_flappy_game_engine;

    logic       clk = 1'b0;
    logic       reset, start, flap, tick;
    logic [9:0] bird_y, pipe1_x, pipe1_gap, pipe2_x, pipe2_gap;
    logic [7:0] score;
    logic       hit, q_I, q_flap, q_hit, q_hitrest;

    always #5 clk = ~clk;

    flappy_game_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flap      (flap),
        .tick      (tick),
        .bird_y    (bird_y),
        .pipe1_x   (pipe1_x),
        .pipe1_gap (pipe1_gap),
        .pipe2_x   (pipe2_x),
        .pipe2_gap (pipe2_gap),
        .score     (score),
        .hit       (hit),
        .q_I       (q_I),
        .q_flap    (q_flap),
        .q_hit     (q_hit),
        .q_hitrest (q_hitrest)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference game model (0 INIT, 1 FLAP, 2 HIT, 3 HITREST)
    int m_y, m_vel, m_p1x, m_p2x, m_g1, m_g2, m_score, m_st;
    logic [15:0] m_lfsr;

    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= (m_lfsr >> 1) | (16'(m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_y = 240; m_vel = 0; m_p1x = 640; m_p2x = 960;
        m_g1 = 160; m_g2 = 200; m_score = 0; m_st = 0;
    endtask

    function automatic bit hits_pipe(int x, int g, int y);
        return (x < 340) && (x + 40 > 320) && ((y < g) || (y + 20 > g + 120));
    endfunction

    task automatic model_tick(input bit fl);
        int nx1, nx2, ng1, ng2, inc;
        logic [15:0] lf;
        lf = m_lfsr;
        if (m_st == 1) begin
            m_vel = fl ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
            m_y   = m_y + m_vel;
            if (m_y < 0)   m_y = 0;
            if (m_y > 440) m_y = 440;
            nx1 = (m_p1x < 2) ? 640 : m_p1x - 2;
            nx2 = (m_p2x < 2) ? 640 : m_p2x - 2;
            ng1 = (m_p1x < 2) ? 40 + int'(lf[7:0])  : m_g1;
            ng2 = (m_p2x < 2) ? 40 + int'(lf[15:8]) : m_g2;
            inc = ((m_p1x + 40 >= 320 && nx1 + 40 < 320) ? 1 : 0) +
                  ((m_p2x + 40 >= 320 && nx2 + 40 < 320) ? 1 : 0);
            m_score = (m_score + inc > 255) ? 255 : m_score + inc;
            m_p1x = nx1; m_p2x = nx2; m_g1 = ng1; m_g2 = ng2;
            if (m_y + 20 >= 460 || hits_pipe(nx1, ng1, m_y) || hits_pipe(nx2, ng2, m_y)) m_st = 2;
        end else if (m_st == 2) begin
            m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
            m_y   = (m_y + m_vel > 440) ? 440 : m_y + m_vel;
            if (m_y == 440) m_st = 3;
        end
    endtask

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic push_model();
        push("bird_y", m_y);
        push("pipe1_x", m_p1x);
        push("pipe1_gap", m_g1);
        push("pipe2_x", m_p2x);
        push("pipe2_gap", m_g2);
        push("score", m_score);
        push("onehot", 8 >> m_st);
        push("hit", (m_st >= 2) ? 1 : 0);
    endtask

    task automatic compare_all();
        pop_check(32'(bird_y));
        pop_check(32'(pipe1_x));
        pop_check(32'(pipe1_gap));
        pop_check(32'(pipe2_x));
        pop_check(32'(pipe2_gap));
        pop_check(32'(score));
        pop_check(32'({q_I, q_flap, q_hit, q_hitrest}));
        pop_check(32'(hit));
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input int v);
        push(tag, v);
        pop_check(obs);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input bit fl);
        model_tick(fl);
        push_model();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        compare_all();
    endtask

    task automatic pulse_flap();
        flap = 1'b1;
        cyc();
        flap = 1'b0;
        cyc();
    endtask

    task automatic press_start(input bit with_tick);
        if (m_st == 0)      m_st = 1;
        else if (m_st == 3) model_reset();
        push_model();
        start = 1'b1;
        tick  = with_tick;
        cyc();
        start = 1'b0;
        tick  = 1'b0;
        compare_all();
        cyc();
    endtask

    initial begin
        int k;
        bit fl;
        reset = 1'b1; start = 1'b0; flap = 1'b0; tick = 1'b0;
        cyc();
        cyc();
        model_reset();
        push_model();
        compare_all();
        reset = 1'b0;
        cyc();

        // INIT ignores ticks and flaps; a tick coinciding with the start edge is dropped
        do_tick(0);
        pulse_flap();
        press_start(1);

        // Free fall: vel 1..8,8,8 gives 240+52
        for (int i = 0; i < 10; i++) do_tick(0);
        expect_now("t1_bird_y", 32'(bird_y), 292);
        expect_now("t1_pipe1_x", 32'(pipe1_x), 620);
        expect_now("t1_q_flap", 32'(q_flap), 1);

        // Two flap edges before one tick collapse into a single flap
        pulse_flap();
        pulse_flap();
        do_tick(1);
        expect_now("t2_bird_y", 32'(bird_y), 286);
        do_tick(0);
        expect_now("t2_bird_y_next", 32'(bird_y), 281);

        // Hover through pipe1 (scores at tick 181) until pipe1 respawns at tick 321
        k = 12;
        while (k < 321) begin
            fl = (m_y >= 240);
            if (fl) pulse_flap();
            do_tick(fl);
            k++;
            if (k == 180) expect_now("t5_score_before", 32'(score), 0);
            if (k == 181) expect_now("t5_score_pass", 32'(score), 1);
        end
        expect_now("t3_pipe1_respawn_x", 32'(pipe1_x), 640);
        expect_now("t3_pipe1_gap_range", 32'(pipe1_gap >= 10'd40 && pipe1_gap <= 10'd295), 1);

        // Climb above pipe2's gap while it overlaps the bird
        for (int i = 0; i < 20 && m_st == 1; i++) begin
            pulse_flap();
            do_tick(1);
        end
        expect_now("t5_q_hit", 32'(q_hit), 1);
        expect_now("t5_score_kept", 32'(score), 1);

        // HIT: flap ignored, bird drops to the ground then rests
        pulse_flap();
        for (int i = 0; i < 100 && m_st == 2; i++) do_tick(0);
        expect_now("t5_rest_bird_y", 32'(bird_y), 440);
        expect_now("t5_q_hitrest", 32'(q_hitrest), 1);
        do_tick(0);
        press_start(0);
        expect_now("t4_restart_score", 32'(score), 0);

        // Ground collision with no flaps
        press_start(0);
        for (int i = 0; i < 200 && m_st != 3; i++) do_tick(0);
        expect_now("t4_ground_bird_y", 32'(bird_y), 440);
        expect_now("t4_ground_hit", 32'(hit), 1);
        press_start(0);
        expect_now("t4_reinit_bird_y", 32'(bird_y), 240);

        // Reset mid-flight with both buttons held
        press_start(0);
        for (int i = 0; i < 3; i++) do_tick(0);
        start = 1'b1;
        flap  = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        model_reset();
        push_model();
        compare_all();
        cyc();
        do_tick(0);
        expect_now("t6_held_start_q_I", 32'(q_I), 1);
        start = 1'b0;
        cyc();
        press_start(0);
        expect_now("t6_repress_q_flap", 32'(q_flap), 1);
        flap = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
